// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmitter: accepts one word over a valid/ready handshake and sends
//   it LSB-first on txd as start bit, DATA_W data bits, optional parity bit and
//   one or two stop bits. Bit timing comes from the external baud_tick strobe.
//   Data, parity mode and stop-bit count are latched at accept, so config
//   changes never disturb a frame in flight.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   CNT_W       bit-counter width, 2**CNT_W > DATA_W
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   baud_tick   one-clk strobe per bit period
//   tx_valid    tx_data is valid
//   tx_ready    block can accept a word (IDLE only)
//   tx_data     word to send
//   cfg_parity  00 none, 01 even, 10 odd, 11 none
//   cfg_stop2   0: one stop bit, 1: two stop bits
//   txd         serial line, idles high
//   tx_busy     frame in progress (LOAD..STOP)
//   tx_done     one-clk pulse when the last stop bit ends
//
// All outputs are registered; txd only moves on a clk edge that samples
// baud_tick=1 (or on reset).

module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic              stop_cnt, stop_cnt_d;
  logic              par_bit, par_bit_d;
  logic              par_en, par_en_d;
  logic              stop2, stop2_d;
  logic              txd_d, ready_d, busy_d, done_d;
  logic              accept;

  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      stop2    <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par_bit  <= par_bit_d;
      par_en   <= par_en_d;
      stop2    <= stop2_d;
      txd      <= txd_d;
      tx_ready <= ready_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
    end
  end

  // Next-state logic also computes the next value of every registered output,
  // so txd is already the bit for the state being entered.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_bit_d  = par_bit;
    par_en_d   = par_en;
    stop2_d    = stop2;
    txd_d      = txd;
    ready_d    = tx_ready;
    busy_d     = tx_busy;
    done_d     = 1'b0;

    case (state)
      S_IDLE: begin
        // A tick coinciding with accept is deliberately ignored: LOAD first.
        if (accept) begin
          state_d   = S_LOAD;
          shreg_d   = tx_data;
          par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_bit_d = (cfg_parity == 2'b10) ? ~^tx_data : ^tx_data;
          stop2_d   = cfg_stop2;
          txd_d     = 1'b1;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end

      // Align the start bit to a tick so it lasts a full bit period.
      S_LOAD: begin
        if (baud_tick) begin
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          txd_d     = shreg[0];
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          shreg_d   = shreg >> 1;
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            stop_cnt_d = 1'b0;
            if (par_en) begin
              state_d = S_PARITY;
              txd_d   = par_bit;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d = shreg_d[0];
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (stop2 && !stop_cnt) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: instance A (DATA_W=8, tick every 4 clks) and
// instance B (DATA_W=5, tick tied high). Stimulus pushes hand-written frame
// strings (bits in line order) into per-instance queues; the monitor records
// txd after every tick edge inside a frame and compares on tx_done.

module tb_uart_tx_ctrl;

  typedef struct {
    string bits;
    int    gap;   // expected idle ticks between previous tx_done and start; -1 = don't care
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic       clk;
  logic       rst;
  logic       tick_a, tick_b;
  logic       valid_a, valid_b;
  logic [7:0] tx_data_a;
  logic [4:0] tx_data_b;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       ready_a, ready_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;

  logic tick_v [2];
  logic ready_v[2];
  logic txd_v  [2];
  logic busy_v [2];
  logic done_v [2];

  assign tick_v[0]  = tick_a;  assign tick_v[1]  = tick_b;
  assign ready_v[0] = ready_a; assign ready_v[1] = ready_b;
  assign txd_v[0]   = txd_a;   assign txd_v[1]   = txd_b;
  assign busy_v[0]  = busy_a;  assign busy_v[1]  = busy_b;
  assign done_v[0]  = done_a;  assign done_v[1]  = done_b;

  exp_t q0[$];
  exp_t q1[$];
  chk_t chk_q[$];

  int    checks = 0;
  int    passed = 0;
  string got[2];
  int    gap[2];
  logic  tprev[2];
  logic  bprev[2];

  uart_tx_ctrl #(.DATA_W(8), .CNT_W(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (tick_a),
    .tx_valid   (valid_a),
    .tx_ready   (ready_a),
    .tx_data    (tx_data_a),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .txd        (txd_a),
    .tx_busy    (busy_a),
    .tx_done    (done_a)
  );

  uart_tx_ctrl #(.DATA_W(5), .CNT_W(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (tick_b),
    .tx_valid   (valid_b),
    .tx_ready   (ready_b),
    .tx_data    (tx_data_b),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .txd        (txd_b),
    .tx_busy    (busy_b),
    .tx_done    (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud strobe for instance A: one clk high every 4 clks.
  initial begin
    int cnt;
    cnt    = 0;
    tick_a = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt    = (cnt + 1) % 4;
      tick_a = (cnt == 0);
    end
  end

  // Monitor / scoreboard: all comparisons are counted here.
  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act === c.exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        got[k]   = "";
        gap[k]   = 0;
        tprev[k] = 1'b0;
        bprev[k] = 1'b0;
      end else begin
        if (tprev[k] && bprev[k] && busy_v[k]) begin
          if (txd_v[k]) got[k] = {got[k], "1"};
          else          got[k] = {got[k], "0"};
        end else if (tprev[k] && !bprev[k]) begin
          gap[k]++;
        end
        if (done_v[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            $display("FAIL unexpected_done inst%0d: got tx_done=1, required 0", k);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            checks++;
            if (got[k] == e.bits) passed++;
            else $display("FAIL frame_bits inst%0d: got %s, required %s", k, got[k], e.bits);
            if (e.gap >= 0) begin
              checks++;
              if (gap[k] == e.gap) passed++;
              else $display("FAIL start_gap inst%0d: got %0d ticks, required %0d", k, gap[k], e.gap);
            end
            checks++;
            if (ready_v[k] === 1'b1) passed++;
            else $display("FAIL ready_after_done inst%0d: got %b, required 1", k, ready_v[k]);
          end
          got[k] = "";
          gap[k] = 0;
        end
        tprev[k] = tick_v[k];
        bprev[k] = busy_v[k];
      end
    end
  end

  task automatic req(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // Present a word; push its expected frame at the accepting edge.
  task automatic send(input int k, input logic [8:0] d, input logic [1:0] p,
                      input logic s2, input string bits, input int g, input bit drop);
    exp_t e;
    int   n;
    e.bits = bits;
    e.gap  = g;
    if (k == 0) begin tx_data_a = d[7:0]; valid_a = 1'b1; end
    else        begin tx_data_b = d[4:0]; valid_b = 1'b1; end
    cfg_parity = p;
    cfg_stop2  = s2;
    n = 0;
    @(negedge clk);
    while (!ready_v[k] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[k]) begin
      req("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    #1;
    if (drop) begin
      if (k == 0) valid_a = 1'b0;
      else        valid_b = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      req("frame_timeout", 32'd0, 32'd1);
      if (k == 0) q0.delete();
      else        q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    tick_b     = 1'b1;
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    tx_data_a  = '0;
    tx_data_b  = '0;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;

    // Reset state, both instances.
    #22;
    req("rst_txd_a",   {31'd0, txd_a},   32'd1);
    req("rst_ready_a", {31'd0, ready_a}, 32'd1);
    req("rst_busy_a",  {31'd0, busy_a},  32'd0);
    req("rst_done_a",  {31'd0, done_a},  32'd0);
    req("rst_txd_b",   {31'd0, txd_b},   32'd1);
    req("rst_ready_b", {31'd0, ready_b}, 32'd1);
    req("rst_busy_b",  {31'd0, busy_b},  32'd0);
    req("rst_done_b",  {31'd0, done_b},  32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5, no parity, 1 stop; tx_valid pulsed while busy must be ignored.
    send(0, 9'h0A5, 2'b00, 1'b0, "0101001011", -1, 1'b1);
    tx_data_a = 8'hFF;
    valid_a   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid_a = 1'b0;
    wait_idle(0);

    // Parity variants.
    send(0, 9'h0A5, 2'b01, 1'b0, "01010010101", -1, 1'b1); wait_idle(0);
    send(0, 9'h0A5, 2'b10, 1'b0, "01010010111", -1, 1'b1); wait_idle(0);
    send(0, 9'h007, 2'b01, 1'b0, "01110000011", -1, 1'b1); wait_idle(0);

    // Two stop bits: 11 bits recorded while busy after the LOAD tick.
    send(0, 9'h000, 2'b00, 1'b1, "00000000011", -1, 1'b1); wait_idle(0);

    // Back-to-back with tx_valid held; config changed during frame 1.
    send(0, 9'h03C, 2'b00, 1'b0, "0001111001", -1, 1'b0);
    send(0, 9'h0C3, 2'b10, 1'b0, "01100001111", 0, 1'b1);
    wait_idle(0);

    // Reset during data bit 4; frame discarded, next frame clean.
    send(0, 9'h05A, 2'b00, 1'b0, "0010110101", -1, 1'b1);
    n = 0;
    while (got[0].len() < 6 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) req("midframe_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    q0.delete();
    rst = 1'b0;
    #1;
    req("midrst_txd",   {31'd0, txd_a},   32'd1);
    req("midrst_ready", {31'd0, ready_a}, 32'd1);
    req("midrst_busy",  {31'd0, busy_a},  32'd0);
    req("midrst_done",  {31'd0, done_a},  32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    send(0, 9'h081, 2'b10, 1'b1, "010000001111", -1, 1'b1);
    wait_idle(0);

    // DATA_W=5, tick tied high: one bit per clk.
    send(1, 9'h015, 2'b00, 1'b0, "0101011", -1, 1'b1);
    wait_idle(1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
